// File: rtl/prbs6_pkg.sv
// Shared PRBS-6 definitions: polynomial taps, checker states and the
// next-bit predictor used by both the checker and the generator bench model.
package prbs6_pkg;

  localparam int unsigned LFSR_W = 6;
  localparam int unsigned TAP_HI = 5;
  localparam int unsigned TAP_LO = 4;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } chk_state_t;

  // x^6 + x^5 + 1, Fibonacci form: next bit is the XOR of the two oldest bits.
  function automatic logic prbs6_next(input logic [LFSR_W-1:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs6_checker_if.sv
// Serial bit stream into the checker plus its lock/error status outputs.
interface prbs6_checker_if #(
  parameter int unsigned ERR_W = 16
) ();

  logic             en;
  logic             din;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;

  // Source side: drives the stream and observes status.
  modport master (
    output en,
    output din,
    output clr_cnt,
    input  locked,
    input  err_pulse,
    input  err_cnt
  );

  // Checker side.
  modport slave (
    input  en,
    input  din,
    input  clr_cnt,
    output locked,
    output err_pulse,
    output err_cnt
  );

endinterface

// File: rtl/prbs6_loss_mon.sv
// Windowed error monitor for the LOCKED state: counts enabled bits in a window
// of WINDOW bits and the errors seen inside it, and strobes loss when the
// error count reaches LOSS_THRESH.
module prbs6_loss_mon #(
  parameter int unsigned WINDOW      = 63,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,  // enabled bit while LOCKED
  input  logic clear,   // hold counters at zero (checker not LOCKED)
  input  logic err,     // current bit mismatches the prediction
  output logic loss
);

  localparam int unsigned BIT_W  = $clog2(WINDOW + 1);
  localparam int unsigned ERR_CW = $clog2(LOSS_THRESH + 1);

  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [ERR_CW-1:0] err_q, err_d, err_sum;
  logic              wrap;

  // Next window state; the current bit's error counts toward loss before any wrap.
  always_comb begin
    err_sum = err_q + ERR_CW'(err);
    wrap    = (bit_q == BIT_W'(WINDOW - 1));
    loss    = active && (err_sum >= ERR_CW'(LOSS_THRESH));
    bit_d   = bit_q;
    err_d   = err_q;
    if (clear || loss) begin
      bit_d = '0;
      err_d = '0;
    end else if (active) begin
      if (wrap) begin
        bit_d = '0;
        err_d = '0;
      end else begin
        bit_d = bit_q + BIT_W'(1);
        err_d = err_sum;
      end
    end
  end

  // Window counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= '0;
      err_q <= '0;
    end else begin
      bit_q <= bit_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/prbs6_checker.sv
// PRBS-6 serial checker: hunts for the pattern, verifies it for LOCK_THRESH
// bits, then flywheels on its own predictions and counts bit errors.
module prbs6_checker
  import prbs6_pkg::*;
#(
  parameter int unsigned LOCK_THRESH = 12,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned WINDOW      = 63,
  parameter int unsigned ERR_W       = 16
) (
  input logic            clk,
  input logic            rst_n,
  prbs6_checker_if.slave bus
);

  chk_state_t        state_q;
  logic [LFSR_W-1:0] s_q;
  logic [2:0]        fill_q;
  logic [7:0]        match_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic [ERR_W-1:0]  err_cnt_q;

  logic pred;
  logic match_ok;
  logic bit_err;
  logic mon_active;
  logic mon_clear;
  logic loss;

  assign pred       = prbs6_next(s_q);
  // An all-zero register is a degenerate LFSR state and never counts as a match.
  assign match_ok   = (bus.din == pred) && (s_q != '0);
  assign bit_err    = (state_q == LOCKED) && (bus.din != pred);
  assign mon_active = bus.en && (state_q == LOCKED);
  assign mon_clear  = (state_q != LOCKED);

  prbs6_loss_mon #(
    .WINDOW      (WINDOW),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_loss_mon (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (mon_active),
    .clear  (mon_clear),
    .err    (bit_err),
    .loss   (loss)
  );

  // Sync FSM, shift register and registered locked/err_pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      s_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.en) begin
        unique case (state_q)
          HUNT: begin
            s_q <= {s_q[LFSR_W-2:0], bus.din};
            if (fill_q == 3'(LFSR_W - 1)) begin
              state_q <= VERIFY;
              fill_q  <= '0;
              match_q <= '0;
            end else begin
              fill_q <= fill_q + 3'd1;
            end
          end
          VERIFY: begin
            s_q <= {s_q[LFSR_W-2:0], bus.din};
            if (match_ok) begin
              if (match_q == 8'(LOCK_THRESH - 1)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                match_q  <= '0;
              end else begin
                match_q <= match_q + 8'd1;
              end
            end else begin
              // Keep the shifted register; HUNT refills it from scratch anyway.
              state_q <= HUNT;
              fill_q  <= '0;
            end
          end
          LOCKED: begin
            // Flywheel on the prediction so a bad bit cannot corrupt later checks.
            s_q         <= {s_q[LFSR_W-2:0], pred};
            err_pulse_q <= bit_err;
            if (loss) begin
              state_q  <= HUNT;
              locked_q <= 1'b0;
              fill_q   <= '0;
              match_q  <= '0;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counter; clr_cnt wins over a same-cycle error and ignores en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      err_cnt_q <= '0;
    end else if (bus.en && bit_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs6_checker.sv
// Scoreboard bench for prbs6_checker: a behavioural model predicts per-cycle
// outputs into queues, a negedge monitor pops and compares them.
module tb_prbs6_checker;
  import prbs6_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prbs6_checker_if #(.ERR_W(16)) bus_a ();
  prbs6_checker_if #(.ERR_W(4))  bus_b ();

  prbs6_checker #(
    .LOCK_THRESH (12),
    .LOSS_THRESH (4),
    .WINDOW      (63),
    .ERR_W       (16)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  prbs6_checker #(
    .LOCK_THRESH (12),
    .LOSS_THRESH (63),
    .WINDOW      (63),
    .ERR_W       (4)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    int       mode;  // 0 hunt, 1 verify, 2 locked
    int       fill;
    int       match;
    int       wbits;
    int       werrs;
    int       cnt;
    bit [5:0] h;     // last six register bits, newest in bit 0
  } mdl_t;

  typedef struct packed {
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
  } exp_t;

  exp_t     q_a[$];
  exp_t     q_b[$];
  mdl_t     ma, mb;
  bit [5:0] ga, gb;
  int       checks = 0;
  int       passes = 0;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endfunction

  function automatic void mdl_reset(output mdl_t m);
    m.mode = 0; m.fill = 0; m.match = 0; m.wbits = 0; m.werrs = 0; m.cnt = 0; m.h = '0;
  endfunction

  task automatic mdl_step(inout mdl_t m, input bit en, input bit din, input bit clr,
                          input int lock_t, input int loss_t, input int win,
                          input int cnt_max, output bit pulse);
    bit p;
    bit nz;
    p     = prbs6_next(m.h);
    nz    = (m.h != 0);
    pulse = 0;
    if (clr) m.cnt = 0;
    if (en) begin
      case (m.mode)
        0: begin
          m.h = {m.h[4:0], din};
          m.fill++;
          if (m.fill == 6) begin m.mode = 1; m.match = 0; m.fill = 0; end
        end
        1: begin
          m.h = {m.h[4:0], din};
          if (din == p && nz) begin
            m.match++;
            if (m.match == lock_t) begin m.mode = 2; m.wbits = 0; m.werrs = 0; end
          end else begin
            m.mode = 0; m.fill = 0;
          end
        end
        default: begin
          m.h = {m.h[4:0], p};
          if (din != p) begin
            pulse = 1;
            if (!clr && m.cnt < cnt_max) m.cnt++;
            m.werrs++;
          end
          m.wbits++;
          if (m.werrs >= loss_t) begin
            m.mode = 0; m.fill = 0; m.match = 0; m.wbits = 0; m.werrs = 0;
          end else if (m.wbits == win) begin
            m.wbits = 0; m.werrs = 0;
          end
        end
      endcase
    end
  endtask

  task automatic gen_next(inout bit [5:0] g, output bit b);
    b = prbs6_next(g);
    g = {g[4:0], b};
  endtask

  // One clock: drive both DUTs, advance the models, queue expected outputs.
  task automatic step(input bit ea, input bit da, input bit ca,
                      input bit eb, input bit db, input bit cb);
    bit   pa, pb;
    exp_t e;
    pa = 0; pb = 0;
    bus_a.en = ea; bus_a.din = da; bus_a.clr_cnt = ca;
    bus_b.en = eb; bus_b.din = db; bus_b.clr_cnt = cb;
    @(posedge clk);
    if (rst_n) begin
      mdl_step(ma, ea, da, ca, 12, 4, 63, 65535, pa);
      mdl_step(mb, eb, db, cb, 12, 63, 63, 15, pb);
    end
    e.locked = (ma.mode == 2); e.pulse = pa; e.cnt = 16'(ma.cnt);
    q_a.push_back(e);
    e.locked = (mb.mode == 2); e.pulse = pb; e.cnt = 16'(mb.cnt);
    q_b.push_back(e);
    #1;
  endtask

  task automatic step_a(input bit e, input bit d, input bit c);
    step(e, d, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clean_a(input bit flip, input bit clr);
    bit b;
    gen_next(ga, b);
    step_a(1'b1, b ^ flip, clr);
  endtask

  task automatic clean_b(input bit flip);
    bit b;
    gen_next(gb, b);
    step(1'b0, 1'b0, 1'b0, 1'b1, b ^ flip, 1'b0);
  endtask

  // Feed clean bits to A until it locks; nbits = enabled bits used, -1 if it never locked.
  task automatic lock_run(input bit rand_en, input int budget, output int nbits,
                          output int npulse);
    bit e, b;
    bit got;
    nbits = 0; npulse = 0; got = 0;
    for (int i = 0; i < budget; i++) begin
      e = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (e) gen_next(ga, b);
      else b = 1'($urandom_range(0, 1));
      step_a(e, b, 1'b0);
      if (e) nbits++;
      npulse += int'(bus_a.err_pulse);
      if (bus_a.locked) begin got = 1; break; end
    end
    if (!got) nbits = -1;
  endtask

  // Assert reset between edges, check outputs clear immediately, release between edges.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mdl_reset(ma);
    mdl_reset(mb);
    #1;
    check({tag, "_locked"}, bus_a.locked, 0);
    check({tag, "_pulse"}, bus_a.err_pulse, 0);
    check({tag, "_cnt"}, bus_a.err_cnt, 0);
    check({tag, "_cnt_b"}, bus_b.err_cnt, 0);
    step_a(1'b0, 1'b0, 1'b0);
    step_a(1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("sb_a", {bus_a.locked, bus_a.err_pulse, bus_a.err_cnt}, e);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("sb_b", {bus_b.locked, bus_b.err_pulse, 12'd0, bus_b.err_cnt}, e);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin : stim
    int  n, np, seen;
    rst_n = 1'b0;
    bus_a.en = 0; bus_a.din = 0; bus_a.clr_cnt = 0;
    bus_b.en = 0; bus_b.din = 0; bus_b.clr_cnt = 0;
    mdl_reset(ma);
    mdl_reset(mb);
    ga = 6'b101011;
    gb = 6'b101011;
    #3;
    check("rst_locked", bus_a.locked, 0);
    check("rst_pulse", bus_a.err_pulse, 0);
    check("rst_cnt", bus_a.err_cnt, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Clean lock from seed 101011, then 200 bits total without errors.
    lock_run(1'b0, 100, n, np);
    check("clean_lock_bits", n, 18);
    for (int i = 18; i < 200; i++) begin
      clean_a(1'b0, 1'b0);
      np += int'(bus_a.err_pulse);
    end
    check("clean_pulses", np, 0);
    check("clean_cnt", bus_a.err_cnt, 0);

    // Single inverted bit, then a flywheel stretch.
    clean_a(1'b1, 1'b0);
    np = int'(bus_a.err_pulse);
    for (int i = 0; i < 62; i++) begin
      clean_a(1'b0, 1'b0);
      np += int'(bus_a.err_pulse);
    end
    check("single_pulses", np, 1);
    check("single_cnt", bus_a.err_cnt, 1);
    check("single_locked", bus_a.locked, 1);

    // Clear with en low, then four errors well inside one window.
    step_a(1'b0, 1'b0, 1'b1);
    check("clr_idle_cnt", bus_a.err_cnt, 0);
    for (int i = 0; i < 63 && ma.wbits > 40; i++) clean_a(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      clean_a(1'b1, 1'b0);
      if (k < 3) begin
        check("loss_hold", bus_a.locked, 1);
        clean_a(1'b0, 1'b0);
      end
    end
    check("loss_locked", bus_a.locked, 0);
    check("loss_pulse", bus_a.err_pulse, 1);
    check("loss_cnt", bus_a.err_cnt, 4);
    lock_run(1'b0, 100, n, np);
    check("relock_bits", n, 18);

    // Stuck-at-0 never locks and never counts.
    do_reset("rst_stuck");
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      step_a(1'b1, 1'b0, 1'b0);
      seen += int'(bus_a.locked);
    end
    check("stuck_locked", seen, 0);
    check("stuck_cnt", bus_a.err_cnt, 0);

    // 50% enable duty on a clean stream from a random seed.
    do_reset("rst_gap");
    ga = 6'($urandom_range(1, 63));
    lock_run(1'b1, 2000, n, np);
    check("gap_lock_bits", n, 18);
    check("gap_pulses", np, 0);

    // clr_cnt together with an error: pulse fires, count clears.
    clean_a(1'b1, 1'b0);
    check("pre_clr_cnt", bus_a.err_cnt, 1);
    clean_a(1'b1, 1'b1);
    check("clr_err_cnt", bus_a.err_cnt, 0);
    check("clr_err_pulse", bus_a.err_pulse, 1);

    // Saturation on the 4-bit counter instance.
    for (int i = 0; i < 18; i++) clean_b(1'b0);
    check("sat_lock", bus_b.locked, 1);
    for (int i = 0; i < 40; i++) clean_b(1'(i % 2));
    check("sat_cnt", bus_b.err_cnt, 15);
    check("sat_locked", bus_b.locked, 1);

    // Async reset mid-LOCKED right after an error, then relock.
    clean_a(1'b1, 1'b0);
    check("pre_rst_pulse", bus_a.err_pulse, 1);
    do_reset("rst_locked");
    lock_run(1'b0, 100, n, np);
    check("rst_relock_bits", n, 18);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prbs6_checker.md
# prbs6_checker

Serial PRBS-6 checker: the receiving end of the 6-bit LFSR pattern generator. It consumes one bit per enabled cycle from the generator's serial output. It self-synchronises its own 6-bit shift register to the incoming stream, declares lock, then flywheels and counts bit errors. It sits at the sink side of the LFSR test path, for loopback and link BIST.

## Interface
- LOCK_THRESH, default 12: consecutive matching bits in VERIFY needed to declare lock (range 1..255).
- LOSS_THRESH, default 4: errors within one window that drop lock (range 1..WINDOW).
- WINDOW, default 63: window length in enabled bits for loss detection (one PRBS-6 period).
- ERR_W, default 16: width of the error counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  din is valid this cycle; when low, all state holds.
- din  in  1  received serial bit.
- clr_cnt  in  1  synchronous clear of err_cnt.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per detected bit error (LOCKED only).
- err_cnt  out  ERR_W  saturating count of errors detected while LOCKED.

## Operation
- Polynomial: x^6 + x^5 + 1, Fibonacci form.
- The register `s[5:0]` holds the last 6 bits. The predicted bit is `p = s[5] ^ s[4]`. A shift is `s <= {s[4:0], b}`.
- State machine, advancing only on `en` cycles:
  - **HUNT**
    - Shift in din (b = din) and increment the fill count.
    - After 6 bits, go to VERIFY with the match count at 0.
  - **VERIFY**
    - Shift in din (b = din).
    - If `din == p` and s is not all-zero: increment the match count. When it reaches LOCK_THRESH, go to LOCKED.
    - Otherwise: go to HUNT with the fill count at 0. The register keeps its shifted contents.
  - **LOCKED**
    - Shift in the prediction (b = p), so errors do not propagate.
    - If `din != p`: pulse err_pulse, increment err_cnt, and increment the window error count.
    - The window bit counter wraps every WINDOW enabled bits and clears the window error count at the wrap.
    - If the window error count reaches LOSS_THRESH, go to HUNT. Fill, match and window counters are cleared on this transition.
- An all-zero register never qualifies as a match. A stuck-at-0 input therefore never locks.
- err_cnt:
  - Saturates at all-ones and does not wrap.
  - clr_cnt has priority: if clr_cnt and an error occur in the same cycle, err_cnt becomes 0 and that error is not counted. err_pulse still fires.
- clr_cnt acts independently of en.
- Errors are never counted in HUNT or VERIFY.

## Timing
- Reset values:
  - state HUNT, s = 0, all counters 0.
  - locked = 0, err_pulse = 0, err_cnt = 0.
- All outputs are registered.
  - locked rises on the clock edge that accepts the LOCK_THRESH-th matching bit.
  - locked falls on the edge that accepts the LOSS_THRESH-th windowed error.
- err_pulse is high for exactly the one cycle after the edge that samples the bad bit. It is 0 on any cycle following an `en = 0` cycle.
- Minimum lock latency from reset on a clean stream: 6 + LOCK_THRESH enabled bits (18 with defaults).
- The lock-loss transition and the error that causes it occur on the same edge. That error still pulses and is counted.
- Asserting rst_n low mid-operation immediately forces all reset values, asynchronously.
- Throughput: one bit per cycle. No backpressure.

## Structure
- Package `prbs6_pkg`:
  - `typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_t`
  - `LFSR_W = 6`, `TAP_HI = 5`, `TAP_LO = 4`
  - function `prbs6_next(s)` returning the predicted bit, shared with the generator's bench model.
- One sub-module, `prbs6_loss_mon`: the window bit counter plus the window error counter. It outputs a loss strobe. The top level holds the FSM, the shift register, and err_cnt/err_pulse.

## Test plan
- **Clean lock:** generator seeded 6'b101011 (bitstream 1,1,1,1,0,0,…) driven with en = 1 continuously.
  - Required: locked rises after exactly 18 bits.
  - Required: err_cnt stays 0 over 200 bits.
- **Single error injection:** invert one bit while locked.
  - Required: exactly one err_pulse.
  - Required: err_cnt = 1.
  - Required: locked stays 1.
  - Required: the next 62 bits produce no further pulses (flywheel).
- **Loss and relock:** inject 4 errors within 63 bits.
  - Required: locked falls on the 4th error.
  - Required: err_cnt = 4.
  - Required: relock occurs 18 bits after clean data resumes.
- **Stuck-at-0 input:** din = 0 for 300 cycles.
  - Required: locked never asserts.
  - Required: err_cnt stays 0.
- **Gaps and saturation:**
  - Random en duty of 50% on a clean stream: lock after 18 enabled bits; no pulses.
  - With ERR_W = 4 and LOSS_THRESH = 63, invert every 2nd bit: err_cnt saturates at 15.
  - Assert clr_cnt together with an error: err_cnt becomes 0.
- **Async reset:** assert rst_n mid-LOCKED, between clock edges.
  - Required: locked, err_pulse and err_cnt read 0 immediately.
  - Required: relock takes 18 bits after release.
